// File: rtl/LLC_defs.sv
// Shared LLC bus definitions: operation and snoop codes,
// responder states and the address-based snoop rule.
package LLC_defs;

  typedef enum logic [2:0] {
    NOBUSOP    = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } busOperation;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoopResults;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNOOP   = 3'd1,
    MEMWAIT = 3'd2,
    SEND    = 3'd3,
    SINK    = 3'd4
  } rsp_state_t;

  // Other caches never claim a line that the LLC is writing back.
  function automatic snoopResults snoop_of(
    input busOperation op,
    input logic [1:0]  lo
  );
    snoopResults r;
    r = NOHIT;
    if (op != WRITE) begin
      unique case (lo)
        2'b00:   r = HIT;
        2'b01:   r = HITM;
        default: r = NOHIT;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/llc_sat_counter.sv
// 32-bit event counter that sticks at all-ones
// instead of wrapping.
module llc_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  // Count one event per cycle, holding at the ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/llc_bus_responder.sv
// Bus-side responder for the LLC: models peer snoops
// and memory, sourcing or sinking one line per op.
module llc_bus_responder
  import LLC_defs::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int LINE_BYTES    = 64,
  parameter int SNOOP_LATENCY = 2,
  parameter int MEM_LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  busOperation           req_busop,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  snoop_valid,
  output snoopResults           snoop_result,
  output logic                  data_valid,
  output logic                  data_last,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] wr_checksum,
  output logic                  busy,
  output logic [31:0]           cnt_reads,
  output logic [31:0]           cnt_writes,
  output logic [31:0]           cnt_invals,
  output logic [31:0]           cnt_rwims
);

  localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int BPB   = DATA_WIDTH / 8;
  localparam int M1    = (SNOOP_LATENCY > MEM_LATENCY) ?
                         SNOOP_LATENCY : MEM_LATENCY;
  localparam int M2    = (M1 > BEATS) ? M1 : BEATS;
  localparam int CW    = $clog2(M2 + 1);

  rsp_state_t            state;
  rsp_state_t            state_nxt;
  busOperation           op;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         wait_len;
  logic [DATA_WIDTH-1:0] acc;
  snoopResults           res;
  logic                  accept;
  logic                  snoop_done;
  logic                  wait_done;
  logic                  send_done;
  logic                  sink_done;

  assign accept     = req_valid && req_ready &&
                      (req_busop != NOBUSOP);
  assign res        = snoop_of(op, addr_q[1:0]);
  assign line_base  = addr_q & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign snoop_done = (state == SNOOP) &&
                      (cnt == CW'(SNOOP_LATENCY - 1));
  assign wait_done  = (state == MEMWAIT) &&
                      (cnt == wait_len - CW'(1));
  assign send_done  = (state == SEND) && (cnt == CW'(BEATS - 1));
  assign sink_done  = (state == SINK) && data_in_valid &&
                      (cnt == CW'(BEATS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SNOOP;
      SNOOP: begin
        if (snoop_done) begin
          unique case (op)
            INVALIDATE: state_nxt = IDLE;
            WRITE:      state_nxt = SINK;
            default:    state_nxt = MEMWAIT;
          endcase
        end
      end
      MEMWAIT: if (wait_done) state_nxt = SEND;
      SEND:    if (send_done) state_nxt = IDLE;
      SINK:    if (sink_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; data beats walk up the line.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    data_valid = (state == SEND);
    data_last  = send_done;
    data_out   = '0;
    if (state == SEND) begin
      data_out = DATA_WIDTH'(line_base) +
                 DATA_WIDTH'(cnt) * DATA_WIDTH'(BPB);
    end
  end

  // Request latch, latency/beat counting, snoop pulse and
  // write-back accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op           <= NOBUSOP;
      addr_q       <= '0;
      cnt          <= '0;
      wait_len     <= '0;
      acc          <= '0;
      wr_checksum  <= '0;
      snoop_valid  <= 1'b0;
      snoop_result <= NOHIT;
    end else begin
      snoop_valid <= 1'b0;
      if (accept) begin
        op     <= req_busop;
        addr_q <= req_addr;
        cnt    <= '0;
        acc    <= '0;
      end else if (snoop_done) begin
        snoop_valid  <= 1'b1;
        snoop_result <= res;
        cnt          <= '0;
        wait_len     <= (res == HITM) ? CW'(1) : CW'(MEM_LATENCY);
      end else if (wait_done || send_done) begin
        cnt <= '0;
      end else if (state == SINK) begin
        if (data_in_valid) begin
          acc <= acc ^ data_in;
          cnt <= cnt + CW'(1);
          if (sink_done) begin
            wr_checksum <= acc ^ data_in;
            cnt         <= '0;
          end
        end
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  llc_sat_counter u_cnt_reads (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && (req_busop == READ)),
    .count (cnt_reads)
  );

  llc_sat_counter u_cnt_writes (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && (req_busop == WRITE)),
    .count (cnt_writes)
  );

  llc_sat_counter u_cnt_invals (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && (req_busop == INVALIDATE)),
    .count (cnt_invals)
  );

  llc_sat_counter u_cnt_rwims (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && (req_busop == RWIM)),
    .count (cnt_rwims)
  );

endmodule

// File: tb/tb_llc_bus_responder.sv
// Scoreboard bench for llc_bus_responder: expected snoop
// pulses and data beats are queued at issue time.
module tb_llc_bus_responder;
  import LLC_defs::*;

  localparam int LAT   = 2;
  localparam int MEMW  = 4;
  localparam int BEATS = 8;

  typedef struct {
    int          cyc;
    snoopResults res;
  } snp_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  busOperation req_busop;
  logic [31:0] req_addr;
  logic        snoop_valid;
  snoopResults snoop_result;
  logic        data_valid;
  logic        data_last;
  logic [63:0] data_out;
  logic        data_in_valid;
  logic [63:0] data_in;
  logic [63:0] wr_checksum;
  logic        busy;
  logic [31:0] cnt_reads;
  logic [31:0] cnt_writes;
  logic [31:0] cnt_invals;
  logic [31:0] cnt_rwims;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  snp_t  snoop_q[$];
  beat_t beat_q[$];

  llc_bus_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_busop     (req_busop),
    .req_addr      (req_addr),
    .snoop_valid   (snoop_valid),
    .snoop_result  (snoop_result),
    .data_valid    (data_valid),
    .data_last     (data_last),
    .data_out      (data_out),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .wr_checksum   (wr_checksum),
    .busy          (busy),
    .cnt_reads     (cnt_reads),
    .cnt_writes    (cnt_writes),
    .cnt_invals    (cnt_invals),
    .cnt_rwims     (cnt_rwims)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snoopResults model_snoop(
    input busOperation op,
    input logic [31:0] a
  );
    if (op == WRITE) return NOHIT;
    if (a[1:0] == 2'b00) return HIT;
    if (a[1:0] == 2'b01) return HITM;
    return NOHIT;
  endfunction

  function automatic void push_expect(
    input busOperation op,
    input logic [31:0] a,
    input int          t0
  );
    snp_t        s;
    beat_t       b;
    int          w;
    logic [31:0] base;
    s.cyc = t0 + LAT;
    s.res = model_snoop(op, a);
    snoop_q.push_back(s);
    if (op == READ || op == RWIM) begin
      w    = (s.res == HITM) ? 1 : MEMW;
      base = {a[31:6], 6'b0};
      for (int k = 0; k < BEATS; k++) begin
        b.cyc  = t0 + LAT + w + k;
        b.data = {32'h0, base + 32'(k * 8)};
        b.last = (k == BEATS - 1);
        beat_q.push_back(b);
      end
    end
  endfunction

  // Scoreboard: pop and compare every DUT output event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (snoop_valid) begin
        n_cmp++;
        if (snoop_q.size() == 0) begin
          n_err++;
          $display("FAIL snoop_unexpected cyc=%0d got=%0d",
                   cyc, snoop_result);
        end else begin
          snp_t e;
          e = snoop_q.pop_front();
          if (cyc !== e.cyc || snoop_result !== e.res) begin
            n_err++;
            $display("FAIL snoop cyc=%0d res=%0d exp cyc=%0d res=%0d",
                     cyc, snoop_result, e.cyc, e.res);
          end
        end
      end
      if (data_valid) begin
        n_cmp++;
        if (beat_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected cyc=%0d got=%h", cyc, data_out);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          if (cyc !== e.cyc || data_out !== e.data ||
              data_last !== e.last) begin
            n_err++;
            $display("FAIL beat cyc=%0d d=%h l=%b exp cyc=%0d d=%h l=%b",
                     cyc, data_out, data_last, e.cyc, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic issue(input busOperation op, input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_busop = op;
    req_addr  = a;
    push_expect(op, a, cyc + 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_busop = NOBUSOP;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!busy && snoop_q.size() == 0 && beat_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout busy=%b snq=%0d bq=%0d exp idle+empty",
               name, busy, snoop_q.size(), beat_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy, snoop_valid, data_valid, data_last} !== 5'b10000
        || snoop_result !== NOHIT || data_out !== 64'h0
        || wr_checksum !== 64'h0) begin
      n_err++;
      $display("FAIL reset_outputs rdy=%b busy=%b sv=%b dv=%b res=%0d exp rdy=1 rest 0",
               req_ready, busy, snoop_valid, data_valid, snoop_result);
    end
    n_cmp++;
    if ({cnt_reads, cnt_writes, cnt_invals, cnt_rwims} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp 0",
               cnt_reads, cnt_writes, cnt_invals, cnt_rwims);
    end
  endtask

  task automatic test_nobusop();
    @(negedge clk);
    req_valid = 1'b1;
    req_busop = NOBUSOP;
    req_addr  = 32'h0000_1040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL nobusop_state busy=%b rdy=%b exp 0/1",
                 busy, req_ready);
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if ({cnt_reads, cnt_writes, cnt_invals, cnt_rwims} !== 128'h0) begin
      n_err++;
      $display("FAIL nobusop_counters got=%0d/%0d/%0d/%0d exp 0",
               cnt_reads, cnt_writes, cnt_invals, cnt_rwims);
    end
  endtask

  task automatic test_read_hit();
    issue(READ, 32'h0000_1040);
    wait_idle("read_hit");
    n_cmp++;
    if (cnt_reads !== 32'd1) begin
      n_err++;
      $display("FAIL read_hit_count got=%0d exp=1", cnt_reads);
    end
  endtask

  task automatic test_read_hitm();
    issue(READ, 32'h0000_1041);
    wait_idle("read_hitm");
    n_cmp++;
    if (cnt_reads !== 32'd2) begin
      n_err++;
      $display("FAIL read_hitm_count got=%0d exp=2", cnt_reads);
    end
  endtask

  task automatic test_write();
    issue(WRITE, 32'h0000_2000);
    @(negedge clk);
    @(negedge clk);
    data_in_valid = 1'b1;
    data_in       = 64'h100;
    for (int k = 1; k <= BEATS; k++) begin
      @(negedge clk);
      if (k == 5) begin
        data_in_valid = 1'b0;
        @(negedge clk);
      end
      data_in_valid = 1'b1;
      data_in       = 64'(k);
      if (k == BEATS) begin
        n_cmp++;
        if (wr_checksum !== 64'h0) begin
          n_err++;
          $display("FAIL write_early_checksum got=%h exp=0", wr_checksum);
        end
      end
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    data_in       = 64'h0;
    wait_idle("write");
    n_cmp++;
    if (wr_checksum !== 64'h8) begin
      n_err++;
      $display("FAIL write_checksum got=%h exp=8", wr_checksum);
    end
    n_cmp++;
    if (cnt_writes !== 32'd1) begin
      n_err++;
      $display("FAIL write_count got=%0d exp=1", cnt_writes);
    end
  endtask

  task automatic test_back_to_back();
    int  t0;
    int  t1;
    bit  seen;
    @(negedge clk);
    t0        = cyc + 1;
    req_valid = 1'b1;
    req_busop = INVALIDATE;
    req_addr  = 32'h0000_3002;
    push_expect(INVALIDATE, 32'h0000_3002, t0);
    @(posedge clk);
    #1;
    req_busop = RWIM;
    req_addr  = 32'h0000_3003;
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy busy=%b rdy=%b exp 1/0", busy, req_ready);
    end
    seen = 1'b0;
    t1   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = 1'b1;
        t1   = cyc + 1;
        push_expect(RWIM, 32'h0000_3003, t1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_busop = NOBUSOP;
    n_cmp++;
    if (!seen || t1 !== t0 + 3) begin
      n_err++;
      $display("FAIL b2b_accept seen=%b t1=%0d exp t1=%0d", seen, t1, t0 + 3);
    end
    wait_idle("b2b");
    n_cmp++;
    if (cnt_invals !== 32'd1 || cnt_rwims !== 32'd1) begin
      n_err++;
      $display("FAIL b2b_counts inv=%0d rwim=%0d exp 1/1",
               cnt_invals, cnt_rwims);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    issue(READ, 32'h0000_1040);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (beat_q.size() == BEATS - 3) begin
        hit = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!hit || data_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs hit=%b dv=%b busy=%b exp 1/0/0",
               hit, data_valid, busy);
    end
    n_cmp++;
    if ({cnt_reads, cnt_writes, cnt_invals, cnt_rwims} !== 128'h0
        || wr_checksum !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid_state rd=%0d wr=%0d ck=%h exp 0",
               cnt_reads, cnt_writes, wr_checksum);
    end
    snoop_q.delete();
    beat_q.delete();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (data_valid !== 1'b0 || snoop_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_quiet dv=%b sv=%b exp 0/0",
               data_valid, snoop_valid);
    end
    rst_n = 1'b1;
    issue(READ, 32'h0000_1040);
    wait_idle("reset_mid_read");
    n_cmp++;
    if (cnt_reads !== 32'd1) begin
      n_err++;
      $display("FAIL reset_mid_count got=%0d exp=1", cnt_reads);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_busop     = NOBUSOP;
    req_addr      = 32'h0;
    data_in_valid = 1'b0;
    data_in       = 64'h0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_nobusop();
    test_read_hit();
    test_read_hitm();
    test_write();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/llc_bus_responder.md
Name: llc_bus_responder

Overview:
- Bus-side counterpart of the LLC: accepts the bus operations the LLC issues (READ, WRITE, INVALIDATE, RWIM).
- Models other processors' snooping caches and main memory: returns a snoop result, then sources (READ/RWIM) or sinks (WRITE) a full cache line in DATA_WIDTH beats.
- Sits on the LLC's bus port in the cache test environment; it replaces the trace-driven display of busOp/snoopResult with a cycle-accurate responder.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, bus data beat width.
- LINE_BYTES, 64, cache line size in bytes; BEATS = LINE_BYTES*8/DATA_WIDTH (8 at defaults).
- SNOOP_LATENCY, 2, cycles from request accept to snoop result; must be >=1.
- MEM_LATENCY, 4, cycles from snoop result to first memory data beat when no HITM.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  LLC presents a bus operation.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_busop  in  busOperation  operation code from LLC_defs.
- req_addr  in  ADDR_WIDTH  operation address.
- snoop_valid  out  1  one-cycle pulse qualifying snoop_result.
- snoop_result  out  snoopResults  HIT / HITM / NOHIT; held until the next pulse.
- data_valid  out  1  read data beat valid.
- data_last  out  1  final read beat.
- data_out  out  DATA_WIDTH  read data beat.
- data_in_valid  in  1  LLC write-back beat valid.
- data_in  in  DATA_WIDTH  write-back beat.
- wr_checksum  out  DATA_WIDTH  XOR of all beats of the most recent completed WRITE.
- busy  out  1  state != IDLE.
- cnt_reads, cnt_writes, cnt_invals, cnt_rwims  out  32 each  accepted operations per type; saturate at 32'hFFFF_FFFF.

Behaviour:
- Reset: state IDLE; all outputs 0; req_ready 1; snoop_result NOHIT; counters 0. Reset asserted mid-operation aborts immediately, with no further beats or pulses.
- Accept: happens when req_valid && req_ready && req_busop != NOBUSOP. NOBUSOP with valid is ignored (no state change, no count). On accept, latch op and addr, increment the matching counter, and go to SNOOP. The accept edge is cycle 0.
- SNOOP: the counter runs SNOOP_LATENCY cycles. snoop_valid pulses in cycle SNOOP_LATENCY.
- Result rule for READ/RWIM/INVALIDATE: addr[1:0]=00 gives HIT, 01 gives HITM, 10 or 11 gives NOHIT.
- Result rule for WRITE: always NOHIT.
- After the snoop pulse:
  - INVALIDATE goes to IDLE.
  - WRITE goes to SINK.
  - READ/RWIM go to MEMWAIT with wait = 1 cycle if HITM (cache-to-cache transfer), else MEM_LATENCY cycles.
- MEMWAIT: after the wait expires, go to SEND.
- SEND: BEATS consecutive cycles of data_valid.
  - data_out for beat k = line base (addr with low log2(LINE_BYTES) bits cleared) + k*DATA_WIDTH/8, zero-extended.
  - data_last is asserted with beat BEATS-1; the following cycle is IDLE.
- SINK: counts data_in_valid beats (gaps allowed, no timeout) and XOR-accumulates data_in.
  - After BEATS beats, update wr_checksum and go to IDLE.
  - data_in_valid outside SINK is ignored.
- req_ready is low in all non-IDLE states. A held req_valid is accepted on the first IDLE cycle, so back-to-back ops are separated by at least the full operation length.
- The beat counter and latency counters are sized from parameters. No wrap occurs because counts are bounded by BEATS and the latencies.

Decomposition:
- LLC_defs holds:
  - busOperation and snoopResults enums.
  - Responder state enum (IDLE, SNOOP, MEMWAIT, SEND, SINK).
  - Snoop-result-from-address function, so that the LLC and this model agree.
- One sub-module: llc_sat_counter (32-bit saturating increment), instantiated four times.

Test Plan:
- READ 0x0000_1040 → snoop_valid at cycle 2 with HIT. First beat at cycle 6, data_out 0x1040, 0x1048, …, 0x1078; data_last on the 8th beat; cnt_reads=1.
- READ 0x0000_1041 → HITM at cycle 2; first beat at cycle 3 with data_out 0x1040.
- WRITE 0x0000_2000, data_in 1..8 with one idle gap → NOHIT at cycle 2; wr_checksum=8 after the 8th beat; cnt_writes=1; data_valid never asserts.
- INVALIDATE 0x0000_3002 then RWIM 0x0000_3003 with req_valid held → NOHIT for each, second accepted only after busy drops; cnt_invals=1, cnt_rwims=1.
- NOBUSOP with req_valid=1 → no state change, all counters 0.
- rst_n low during beat 3 of SEND → data_valid=0 and busy=0 asynchronously, counters 0; a new READ afterwards completes normally.
